z80_bus_arbiter: RTL



---
 rtl/z80_arb_pkg.sv | 18 +
 rtl/z80_arb_timer.sv | 27 ++
 rtl/z80_bus_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/z80_arb_pkg.sv
// Shared types and constants for the Z80 bus arbiter.
// Z80_ARB_BURST_EN enables back-to-back host cycles without a bus release.
package z80_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_RELEASE
  } arb_state_t;

endpackage

// File: rtl/z80_arb_timer.sv
// Loadable down-counter for the REQ timeout and T2 wait states.
// Saturates at zero so a held state keeps zero asserted.
module z80_arb_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/z80_bus_arbiter.sv
// Host/Z80 bus arbiter: /BUSRQ handshake, one T1/T2/T3 host cycle, release.
// Z80_ARB_BURST_EN keeps the bus for a request arriving right after ack.
module z80_bus_arbiter
  import z80_arb_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 64
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic              host_err,
  output logic              z80_busrq_n,
  input  logic              z80_busak_n,
  input  logic              wait_n,
  output logic              owner,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_dout,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] bus_din,
  output logic              bus_mreq_n,
  output logic              bus_rd_n,
  output logic              bus_wr_n
);

`ifdef Z80_ARB_BURST_EN
  localparam logic BURST = 1'b1;
`else
  localparam logic BURST = 1'b0;
`endif

  localparam logic [7:0] TO_LOAD = 8'(TIMEOUT - 1);
  localparam logic [7:0] WS_LOAD = 8'(WAIT_STATES);

  arb_state_t        state;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic       tmr_load;
  logic       tmr_dec;
  logic [7:0] tmr_val;
  logic [7:0] tmr_count;
  logic       tmr_zero;

  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = 8'd0;
    unique case (state)
      ST_IDLE: begin
        tmr_load = host_req;
        tmr_val  = TO_LOAD;
      end
      ST_REQ: tmr_dec = 1'b1;
      ST_T1: begin
        tmr_load = 1'b1;
        tmr_val  = WS_LOAD;
      end
      ST_T2:   tmr_dec = 1'b1;
      default: ;
    endcase
  end

  z80_arb_timer #(.W(8)) u_timer (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= ST_IDLE;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      z80_busrq_n <= 1'b1;
      owner       <= 1'b0;
      bus_addr    <= '0;
      bus_dout    <= '0;
      bus_oe      <= 1'b0;
      bus_mreq_n  <= STROBE_OFF;
      bus_rd_n    <= STROBE_OFF;
      bus_wr_n    <= STROBE_OFF;
      host_ack    <= 1'b0;
      host_err    <= 1'b0;
      host_rdata  <= '0;
    end else begin
      host_ack <= 1'b0;
      host_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (host_req) begin
            lat_we      <= host_we;
            lat_addr    <= host_addr;
            lat_wdata   <= host_wdata;
            z80_busrq_n <= 1'b0;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!z80_busak_n) begin
            owner    <= 1'b1;
            bus_addr <= lat_addr;
            bus_dout <= lat_wdata;
            bus_oe   <= lat_we;
            state    <= ST_T1;
          end else if (tmr_zero) begin
            host_ack    <= 1'b1;
            host_err    <= 1'b1;
            z80_busrq_n <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_T1: begin
          bus_mreq_n <= 1'b0;
          bus_rd_n   <= lat_we;
          bus_wr_n   <= !lat_we;
          state      <= ST_T2;
        end
        ST_T2: begin
          // Wait states counted first, then /WAIT stretches the last cycle.
          if (tmr_zero && wait_n) begin
            bus_mreq_n <= STROBE_OFF;
            bus_rd_n   <= STROBE_OFF;
            bus_wr_n   <= STROBE_OFF;
            bus_oe     <= 1'b0;
            host_ack   <= 1'b1;
            if (!lat_we) host_rdata <= bus_din;
            state      <= ST_T3;
          end
        end
        ST_T3: begin
          if (BURST && host_req) begin
            lat_we    <= host_we;
            lat_addr  <= host_addr;
            lat_wdata <= host_wdata;
            bus_addr  <= host_addr;
            bus_dout  <= host_wdata;
            bus_oe    <= host_we;
            state     <= ST_T1;
          end else begin
            owner       <= 1'b0;
            z80_busrq_n <= 1'b1;
            state       <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (z80_busak_n) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
